// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared opcodes, FSM encoding and width defaults for the ALU issue
//           controller.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_regfile.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_regfile
// Brief   : 2^RA_W x DATA_W register file, one sync write, three comb reads.
//           ALU_ISSUE_R0_ZERO_EN hardwires register 0 to zero.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_regfile #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RA_W-1:0]   i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [RA_W-1:0]   i_raddr2,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic [RA_W-1:0]   i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    localparam int NREG = 1 << RA_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic              w_wr_en;

`ifdef ALU_ISSUE_R0_ZERO_EN
    assign w_wr_en    = i_we && (i_waddr != '0);
    assign o_rdata1   = (i_raddr1   == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2   = (i_raddr2   == '0) ? '0 : r_regs[i_raddr2];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
`else
    assign w_wr_en    = i_we;
    assign o_rdata1   = r_regs[i_raddr1];
    assign o_rdata2   = r_regs[i_raddr2];
    assign o_dbg_data = r_regs[i_dbg_addr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Issue/writeback controller for an external combinational ALU.
//           Option macro: ALU_ISSUE_R0_ZERO_EN (register 0 reads as zero).
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic              in_imm_sel,
    input  logic [DATA_W-1:0] in_imm,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;

    logic [2:0]        r_alu_opcode;
    logic [DATA_W-1:0] r_alu_op1;
    logic [DATA_W-1:0] r_alu_op2;
    logic [RA_W-1:0]   r_rd;
    logic [DATA_W-1:0] r_result;

    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;

    alu_issue_regfile #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (r_state == ST_WB),
        .i_waddr    (r_rd),
        .i_wdata    (r_result),
        .i_raddr1   (in_rs1),
        .o_rdata1   (w_rs1_data),
        .i_raddr2   (in_rs2),
        .o_rdata2   (w_rs2_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_EXEC;
                end
            end
            ST_EXEC: w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operands are sampled at accept and held, so the ALU inputs are stable
    // through EXEC and keep their last values afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_rd         <= '0;
            r_result     <= '0;
        end else begin
            if (w_accept) begin
                r_alu_opcode <= in_opcode;
                r_alu_op1    <= w_rs1_data;
                r_alu_op2    <= in_imm_sel ? in_imm : w_rs2_data;
                r_rd         <= in_rd;
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign wb_valid     = (r_state == ST_WB);
    assign wb_rd        = r_rd;
    assign wb_data      = r_result;
    assign alu_opcode   = r_alu_opcode;
    assign alu_operand1 = r_alu_op1;
    assign alu_operand2 = r_alu_op2;

endmodule
`default_nettype wire
